// File: rtl/alu_result_stage_if.sv
// Handshake bus for the ALU result stage: adder-side input and writeback-side output.
interface alu_result_stage_if #(
  parameter int unsigned N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         a_msb;
  logic         b_msb;
  logic         upd_flags;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic [3:0]   out_flags;

  // Driver side: feeds adder results in, drains results out
  modport master (
    output in_valid, sum, cout, a_msb, b_msb, upd_flags, out_ready,
    input  in_ready, out_valid, result, out_flags
  );

  // Stage side
  modport slave (
    input  in_valid, sum, cout, a_msb, b_msb, upd_flags, out_ready,
    output in_ready, out_valid, result, out_flags
  );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result stage: computes N/Z/C/V from the adder outputs, buffers result+flags
// in a 2-entry skid buffer, and keeps the architectural flag register whose C bit
// is fed back to the adder carry input.
module alu_result_stage #(
  parameter int unsigned N = 8
) (
  input  logic                clk,
  input  logic                rst,
  alu_result_stage_if.slave   bus,
  input  logic                flag_clr,
  output logic [3:0]          flags,
  output logic                carry_fb
);

  typedef struct packed {
    logic [N-1:0] sum;
    logic [3:0]   fl;   // {N,Z,C,V}
  } entry_t;

  // head_q is the output register; skid_q holds the second entry when full
  logic [1:0] count_q, count_d;
  entry_t     head_q, head_d;
  entry_t     skid_q, skid_d;
  logic [3:0] flags_q, flags_d;

  entry_t     new_c;
  logic       accept_c;
  logic       xfer_c;

  // Flag computation on the incoming adder word
  always_comb begin
    new_c.sum = bus.sum;
    new_c.fl  = {bus.sum[N-1],
                 (bus.sum == '0),
                 bus.cout,
                 (bus.a_msb == bus.b_msb) && (bus.sum[N-1] != bus.a_msb)};
  end

  assign accept_c = bus.in_valid && (count_q != 2'd2);
  assign xfer_c   = bus.out_ready && (count_q != 2'd0);

  // Next-state for buffer occupancy, entries and flag register
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    skid_d  = skid_q;
    flags_d = flags_q;

    unique case ({accept_c, xfer_c})
      2'b10: begin
        count_d = count_q + 2'd1;
        if (count_q == 2'd0) head_d = new_c;
        else                 skid_d = new_c;
      end
      2'b01: begin
        count_d = count_q - 2'd1;
        if (count_q == 2'd2) head_d = skid_q;
      end
      2'b11: begin
        // Occupancy unchanged: head advances, new word goes behind it
        if (count_q == 2'd1) begin
          head_d = new_c;
        end else begin
          head_d = skid_q;
          skid_d = new_c;
        end
      end
      default: ;
    endcase

    // An accepted update takes priority over a clear in the same cycle
    if (accept_c && bus.upd_flags) flags_d = new_c.fl;
    else if (flag_clr)             flags_d = 4'b0000;
  end

  // State registers with synchronous reset discarding buffered entries
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= '0;
      skid_q  <= '0;
      flags_q <= 4'b0000;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      flags_q <= flags_d;
    end
  end

  assign bus.in_ready  = (count_q != 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.result    = head_q.sum;
  assign bus.out_flags = head_q.fl;
  assign flags         = flags_q;
  assign carry_fb      = flags_q[1];

endmodule
